// File: rtl/hsstl_rx_lane_retry_sched_v1_0.sv
// Per-lane RX recovery scheduler: round-robin grant of one lane at a time,
// soft-reset pulse, wait for init_done, bounded retries with sticky exhaustion.
module hsstl_rx_lane_retry_sched_v1_0 #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned TMR_WIDTH        = 16,
  parameter int unsigned INIT_TIMEOUT     = 50000,
  parameter int unsigned MAX_RETRY        = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] lane_mask,
  input  logic [3:0] lane_err,
  input  logic [3:0] init_done,
  output logic [3:0] rxlane_soft_rst_n,
  output logic       busy,
  output logic [1:0] cur_lane,
  output logic [3:0] lane_ok,
  output logic [3:0] retry_exhausted
);

  localparam int unsigned PW = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0]        PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [PW-1:0]        PULSE_ONE   = PW'(1);
  localparam logic [TMR_WIDTH-1:0] TMR_LAST    = TMR_WIDTH'(INIT_TIMEOUT - 1);
  localparam logic [TMR_WIDTH-1:0] TMR_ONE     = TMR_WIDTH'(1);
  localparam logic [2:0]           RETRY_LIMIT = 3'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           rr;
  logic [PW-1:0]        pulse_cnt;
  logic [TMR_WIDTH-1:0] timer;
  logic                 done_low_seen;
  logic [2:0]           retry_cnt [4];

  logic [3:0] pend;
  logic       grant_vld;
  logic [1:0] grant_lane;
  logic [1:0] idx;
  logic       abort;
  logic       pulse_end;
  logic       success;
  logic       timeout;
  logic [2:0] retry_inc;
  logic       exhaust_now;

  always_comb begin
    pend       = {4{enable}} & lane_mask & lane_err & ~retry_exhausted;
    grant_vld  = 1'b0;
    grant_lane = rr;
    idx        = rr;
    // search rr, rr+1, rr+2, rr+3 (mod 4); first hit wins
    for (int unsigned k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!grant_vld && pend[idx]) begin
        grant_vld  = 1'b1;
        grant_lane = idx;
      end
    end

    abort       = (state != IDLE) && (!enable || !lane_mask[cur_lane]);
    pulse_end   = (state == ASSERT) && (pulse_cnt == PULSE_LAST);
    success     = (state == WAIT_DONE) && init_done[cur_lane] && done_low_seen;
    timeout     = (state == WAIT_DONE) && !success && (timer == TMR_LAST);
    retry_inc   = retry_cnt[cur_lane] + 3'd1;
    exhaust_now = timeout && (retry_inc == RETRY_LIMIT);

    state_nxt = state;
    case (state)
      IDLE:      if (grant_vld) state_nxt = ASSERT;
      ASSERT:    if (pulse_end) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (success || exhaust_now) state_nxt = IDLE;
        else if (timeout)           state_nxt = ASSERT;
      end
      default:   state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxlane_soft_rst_n <= '1;
      cur_lane          <= '0;
      lane_ok           <= '0;
      retry_exhausted   <= '0;
      rr                <= '0;
      pulse_cnt         <= '0;
      timer             <= '0;
      done_low_seen     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) retry_cnt[i] <= '0;
    end else begin
      if (abort) begin
        rxlane_soft_rst_n <= '1;
      end else begin
        case (state)
          IDLE: if (grant_vld) begin
            cur_lane              <= grant_lane;
            lane_ok[grant_lane]   <= 1'b0;
            pulse_cnt             <= '0;
            done_low_seen         <= 1'b0;
            rxlane_soft_rst_n     <= ~(4'b0001 << grant_lane);
          end
          ASSERT: begin
            pulse_cnt <= pulse_cnt + PULSE_ONE;
            if (!init_done[cur_lane]) done_low_seen <= 1'b1;
            if (pulse_end) begin
              timer             <= '0;
              rxlane_soft_rst_n <= '1;
            end
          end
          WAIT_DONE: begin
            timer <= timer + TMR_ONE;
            if (!init_done[cur_lane]) done_low_seen <= 1'b1;
            if (success) begin
              lane_ok[cur_lane]   <= 1'b1;
              retry_cnt[cur_lane] <= '0;
              rr                  <= cur_lane + 2'd1;
            end else if (timeout) begin
              retry_cnt[cur_lane] <= retry_inc;
              if (exhaust_now) begin
                retry_exhausted[cur_lane] <= 1'b1;
                rr                        <= cur_lane + 2'd1;
              end else begin
                // same lane re-enters ASSERT without re-arbitration
                pulse_cnt         <= '0;
                done_low_seen     <= 1'b0;
                rxlane_soft_rst_n <= ~(4'b0001 << cur_lane);
              end
            end
          end
          default: rxlane_soft_rst_n <= '1;
        endcase
      end

      for (int unsigned i = 0; i < 4; i++) begin
        if (!enable || !lane_mask[i]) begin
          retry_cnt[i]       <= '0;
          retry_exhausted[i] <= 1'b0;
          lane_ok[i]         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsstl_rx_lane_retry_sched_v1_0.sv
// Directed bench for the RX lane retry scheduler (pulse 4, timeout 20, 3 retries).
module tb_hsstl_rx_lane_retry_sched_v1_0;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] lane_mask;
  logic [3:0] lane_err;
  logic [3:0] init_done;
  logic [3:0] rxlane_soft_rst_n;
  logic       busy;
  logic [1:0] cur_lane;
  logic [3:0] lane_ok;
  logic [3:0] retry_exhausted;

  int n_cmp = 0;
  int n_err = 0;

  hsstl_rx_lane_retry_sched_v1_0 #(
    .RST_PULSE_CYCLES(4),
    .TMR_WIDTH(16),
    .INIT_TIMEOUT(20),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .lane_mask(lane_mask),
    .lane_err(lane_err),
    .init_done(init_done),
    .rxlane_soft_rst_n(rxlane_soft_rst_n),
    .busy(busy),
    .cur_lane(cur_lane),
    .lane_ok(lane_ok),
    .retry_exhausted(retry_exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // never more than one lane held in soft reset
  always @(negedge clk) begin
    if (rst_n) check("one_hot_low", 32'($countones(~rxlane_soft_rst_n) <= 1), 32'd1);
  end

  task automatic wait_grant(input string tag);
    for (int i = 0; i < 10 && !busy; i++) tick();
    check({tag, "_grant"}, busy, 1);
  endtask

  // successful recovery: done low during the pulse, high 5 cycles after release
  task automatic run_ok(input logic [1:0] lane, input bit one_shot, input string tag);
    logic [3:0] low_pat;
    int n;
    low_pat = 4'b0001 << lane;
    low_pat = ~low_pat;
    wait_grant(tag);
    check({tag, "_cur"}, cur_lane, lane);
    check({tag, "_low"}, rxlane_soft_rst_n, low_pat);
    if (one_shot) lane_err[lane] = 1'b0;
    init_done[lane] = 1'b0;
    repeat (3) tick();
    check({tag, "_low4"}, rxlane_soft_rst_n, low_pat);
    tick();
    check({tag, "_release"}, rxlane_soft_rst_n, 4'hF);
    repeat (4) tick();
    check({tag, "_wait_busy"}, busy, 1);
    check({tag, "_not_ok_yet"}, lane_ok[lane], 0);
    init_done[lane] = 1'b1;
    for (n = 0; n < 10 && busy; n++) tick();
    check({tag, "_done_lat"}, n, 1);
    check({tag, "_ok"}, lane_ok[lane], 1);
    lane_err[lane] = 1'b0;
  endtask

  // three failed attempts: 3 x (4 low + 20 wait) = 72 busy cycles
  task automatic run_exhaust(input logic [1:0] lane, input string tag);
    int elapsed, low, pulses;
    logic prev;
    wait_grant(tag);
    check({tag, "_cur"}, cur_lane, lane);
    elapsed = 0; low = 0; pulses = 0; prev = 1'b1;
    while (busy && elapsed < 200) begin
      if (!rxlane_soft_rst_n[lane]) low++;
      if (!rxlane_soft_rst_n[lane] && prev) pulses++;
      prev = rxlane_soft_rst_n[lane];
      tick();
      elapsed++;
    end
    check({tag, "_elapsed"}, elapsed, 72);
    check({tag, "_low_cycles"}, low, 12);
    check({tag, "_pulses"}, pulses, 3);
    check({tag, "_exhausted"}, retry_exhausted[lane], 1);
    check({tag, "_idle_rst"}, rxlane_soft_rst_n, 4'hF);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; enable = 1'b0; lane_mask = 4'h0; lane_err = 4'h0; init_done = 4'hF;
    repeat (2) tick();
    check("rst_soft", rxlane_soft_rst_n, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_cur", cur_lane, 0);
    check("rst_ok", lane_ok, 4'h0);
    check("rst_exh", retry_exhausted, 4'h0);
    rst_n = 1'b1;
    tick();

    // single recovery on lane 2, one-cycle request
    enable = 1'b1; lane_mask = 4'hF;
    tick();
    lane_err = 4'b0100;
    run_ok(2'd2, 1'b1, "single");
    check("single_idle", busy, 0);
    check("single_lane_ok", lane_ok, 4'b0100);

    // round robin from rr=3: order 3, 0, 1
    lane_err = 4'b1011;
    run_ok(2'd3, 1'b0, "rr3");
    run_ok(2'd0, 1'b0, "rr0");
    run_ok(2'd1, 1'b0, "rr1");
    check("rr_all_ok", lane_ok, 4'hF);

    // lane 1 never completes init
    init_done[1] = 1'b0; lane_err[1] = 1'b1;
    run_exhaust(2'd1, "exh1");
    check("exh1_vec", retry_exhausted, 4'b0010);
    seen = 0;
    repeat (10) begin tick(); if (busy) seen = 1; end
    check("exh1_no_regrant", seen, 0);
    lane_err[1] = 1'b0; init_done[1] = 1'b1;

    // init_done stuck high on lane 0: no low seen, so only timeouts
    lane_err[0] = 1'b1;
    run_exhaust(2'd0, "stuck0");
    check("stuck0_vec", retry_exhausted, 4'b0011);
    lane_err[0] = 1'b0;

    // mask abort on lane 2 in its second pulse; retry count must restart
    lane_err[2] = 1'b1; init_done[2] = 1'b0;
    wait_grant("abort");
    check("abort_cur", cur_lane, 2);
    repeat (25) tick();
    check("abort_2nd_pulse", rxlane_soft_rst_n, 4'b1011);
    lane_mask = 4'b1011;
    tick();
    check("abort_soft", rxlane_soft_rst_n, 4'hF);
    check("abort_busy", busy, 0);
    repeat (3) tick();
    check("abort_masked_idle", busy, 0);
    lane_mask = 4'hF;
    run_exhaust(2'd2, "abort_retry");
    check("abort_retry_vec", retry_exhausted, 4'b0111);
    lane_err[2] = 1'b0; init_done[2] = 1'b1;

    // enable abort clears all flags
    check("en_pre_ok", lane_ok, 4'b1000);
    lane_err[3] = 1'b1;
    wait_grant("en");
    check("en_cur", cur_lane, 3);
    check("en_ok_cleared_on_grant", lane_ok, 4'h0);
    tick();
    enable = 1'b0;
    tick();
    check("en_soft", rxlane_soft_rst_n, 4'hF);
    check("en_busy", busy, 0);
    check("en_exh", retry_exhausted, 4'h0);
    check("en_ok", lane_ok, 4'h0);

    // async reset mid-WAIT_DONE, then arbitration restarts at lane 0
    enable = 1'b1;
    wait_grant("ar");
    check("ar_cur", cur_lane, 3);
    repeat (6) tick();
    check("ar_in_wait", rxlane_soft_rst_n, 4'hF);
    lane_err = 4'b1010;
    tick();
    check("ar_err_change_cur", cur_lane, 3);
    check("ar_err_change_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("ar_soft", rxlane_soft_rst_n, 4'hF);
    check("ar_busy", busy, 0);
    check("ar_cur_rst", cur_lane, 0);
    check("ar_ok", lane_ok, 4'h0);
    check("ar_exh", retry_exhausted, 4'h0);
    #1;
    rst_n = 1'b1;
    tick();
    check("ar_regrant_cur", cur_lane, 1);
    check("ar_regrant_soft", rxlane_soft_rst_n, 4'b1101);
    check("ar_regrant_busy", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
